// File: rtl/tran_bram_fifo.sv
// Synchronous FIFO backed by a single simple-dual-port block RAM.
// Occupancy is tracked with an explicit counter. All flags derive from it.
// Read data is registered, so it is valid one cycle after an accepted read.
module tran_bram_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int AF_LEVEL   = DEPTH - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                     clk_system,
  input  logic                     rst,
  input  logic                     write,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     read,
  input  logic                     clear,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     data_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_flush;
  logic w_rd_req_ok;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_full;
  logic w_empty;

  // Flags come straight from the occupancy counter.
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= CW'(AF_LEVEL));
  assign almost_empty = (r_count <= CW'(AE_LEVEL));
  assign count        = r_count;
  assign data_out     = r_data_out;
  assign data_valid   = r_data_valid;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // rst and clear both block any transfer in their cycle.
  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign w_flush     = rst | clear;
  assign w_rd_req_ok = read && !w_empty;
  assign w_rd_acc    = w_rd_req_ok && !w_flush;
  assign w_wr_acc    = write && (!w_full || w_rd_req_ok) && !w_flush;

  // RAM write port. The RAM has no reset, so the array stays inferable as block RAM.
  always_ff @(posedge clk_system) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // RAM read port with registered output. The value holds unless a read is accepted.
  always_ff @(posedge clk_system) begin
    if (w_flush) begin
      r_data_out <= '0;
    end else if (w_rd_acc) begin
      r_data_out <= r_mem[r_rd_ptr];
    end
  end

  // Pointers, occupancy, the read-valid strobe and the sticky error flags.
  always_ff @(posedge clk_system) begin
    if (w_flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_data_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_data_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (write && !w_wr_acc) begin
        r_overflow <= 1'b1;
      end
      if (read && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tran_bram_fifo.sv
// Directed bench for tran_bram_fifo (DEPTH=8, AF_LEVEL=6, AE_LEVEL=2).
// A vector table covers the main scenarios. Short hand-written sequences cover reset and clear.
module tb_tran_bram_fifo;

  localparam int DW  = 8;
  localparam int DEP = 8;
  localparam int AF  = 6;
  localparam int AE  = 2;

  logic          clk_system = 1'b0;
  logic          rst        = 1'b1;
  logic          write      = 1'b0;
  logic          read       = 1'b0;
  logic          clear      = 1'b0;
  logic [DW-1:0] data_in    = '0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [3:0]    count;
  logic          overflow;
  logic          underflow;

  tran_bram_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEP),
    .AF_LEVEL  (AF),
    .AE_LEVEL  (AE)
  ) dut (
    .clk_system  (clk_system),
    .rst         (rst),
    .write       (write),
    .data_in     (data_in),
    .read        (read),
    .clear       (clear),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk_system = ~clk_system;

  typedef struct {
    logic          wr;
    logic          rd;
    logic          clr;
    logic [DW-1:0] din;
    int            cnt;
    logic          dv;
    logic [DW-1:0] dout;
    logic          ovf;
    logic          udf;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic wr, input logic rd, input logic clr, input logic [DW-1:0] din,
                     input int cnt, input logic dv, input logic [DW-1:0] dout,
                     input logic ovf, input logic udf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.din = din; v.cnt = cnt;
    v.dv = dv; v.dout = dout; v.ovf = ovf; v.udf = udf;
    tbl.push_back(v);
  endtask

  task automatic cmp(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic wr, input logic rd, input logic clr, input logic rs,
                      input logic [DW-1:0] din);
    @(negedge clk_system);
    write = wr; read = rd; clear = clr; rst = rs; data_in = din;
    @(posedge clk_system);
    #1;
  endtask

  task automatic check(input string tag, input int cnt, input logic dv, input logic [DW-1:0] dout,
                       input logic ovf, input logic udf);
    cmp({tag, " count"}, int'(count), cnt);
    cmp({tag, " data_valid"}, int'(data_valid), int'(dv));
    cmp({tag, " data_out"}, int'(data_out), int'(dout));
    cmp({tag, " full"}, int'(full), (cnt == DEP) ? 1 : 0);
    cmp({tag, " empty"}, int'(empty), (cnt == 0) ? 1 : 0);
    cmp({tag, " almost_full"}, int'(almost_full), (cnt >= AF) ? 1 : 0);
    cmp({tag, " almost_empty"}, int'(almost_empty), (cnt <= AE) ? 1 : 0);
    cmp({tag, " overflow"}, int'(overflow), int'(ovf));
    cmp({tag, " underflow"}, int'(underflow), int'(udf));
  endtask

  initial begin
    // Fill to full; almost_full must rise at count 6.
    for (int i = 0; i < 8; i++) add(1, 0, 0, 8'(8'h11 + i), i + 1, 0, 8'h00, 0, 0);
    // Write while full is rejected. Drain returns 0x11..0x18 and never 0x99.
    add(1, 0, 0, 8'h99, 8, 0, 8'h00, 1, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 8'h00, 7 - i, 1, 8'(8'h11 + i), 1, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h18, 1, 0);
    add(0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0);
    // Pointer wrap: 5 in, 5 out, then 6 more words straddle address 7 -> 0.
    for (int i = 0; i < 5; i++) add(1, 0, 0, 8'(i + 1), i + 1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 8'h00, 4 - i, 1, 8'(i + 1), 0, 0);
    for (int i = 0; i < 6; i++) add(1, 0, 0, 8'(8'hA0 + i), i + 1, 0, 8'h05, 0, 0);
    for (int i = 0; i < 6; i++) add(0, 1, 0, 8'h00, 5 - i, 1, 8'(8'hA0 + i), 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'hA5, 0, 0);
    // Empty with write and read together: the write lands and the read underflows.
    add(1, 1, 0, 8'h3C, 1, 0, 8'hA5, 0, 1);
    add(0, 1, 0, 8'h00, 0, 1, 8'h3C, 0, 1);
    add(0, 1, 0, 8'h00, 0, 0, 8'h3C, 0, 1);
    add(0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0);
    // Full with write and read together: both are accepted and count stays at 8.
    for (int i = 0; i < 8; i++) add(1, 0, 0, 8'(8'h21 + i), i + 1, 0, 8'h00, 0, 0);
    add(1, 1, 0, 8'h5A, 8, 1, 8'h21, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 1, 0, 8'h00, 7 - i, 1, 8'(8'h22 + i), 0, 0);
    add(0, 1, 0, 8'h00, 0, 1, 8'h5A, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h5A, 0, 0);
    // Clear right after a read cancels the in-flight data and drops the sticky flags.
    add(0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0);
    add(0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 8'(8'h31 + i), i + 1, 0, 8'h00, 0, 1);
    add(0, 1, 0, 8'h00, 2, 1, 8'h31, 0, 1);
    add(0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0);

    // Reset state.
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    check("reset", 0, 0, 8'h00, 0, 0);

    foreach (tbl[k]) begin
      step(tbl[k].wr, tbl[k].rd, tbl[k].clr, 1'b0, tbl[k].din);
      check($sformatf("vec%0d", k), tbl[k].cnt, tbl[k].dv, tbl[k].dout, tbl[k].ovf, tbl[k].udf);
    end

    // rst in the same cycle as a read: the read is discarded, and old data is gone afterwards.
    step(1, 0, 0, 0, 8'h44);
    step(1, 0, 0, 0, 8'h45);
    check("pre_rst", 2, 0, 8'h00, 0, 0);
    step(0, 1, 0, 1, 8'h00);
    check("rst_with_read", 0, 0, 8'h00, 0, 0);
    step(1, 0, 0, 0, 8'h46);
    step(0, 1, 0, 0, 8'h00);
    check("post_rst_read", 0, 1, 8'h46, 0, 0);

    // rst on the cycle after an accepted read kills the data_valid strobe.
    step(1, 0, 0, 0, 8'h50);
    step(1, 0, 0, 0, 8'h51);
    step(0, 1, 0, 0, 8'h00);
    check("read_before_rst", 1, 1, 8'h50, 0, 0);
    step(0, 0, 0, 1, 8'h00);
    check("rst_after_read", 0, 0, 8'h00, 0, 0);

    // clear wins over a simultaneous write. rst wins over overflow and a write.
    step(1, 0, 1, 0, 8'h60);
    check("clear_vs_write", 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 8'(8'h70 + i));
    check("overflow_set", 8, 0, 8'h00, 1, 0);
    step(1, 0, 0, 1, 8'h7F);
    check("rst_clears_ovf", 0, 0, 8'h00, 0, 0);
    step(0, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    check("empty_after_rst", 0, 0, 8'h00, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tran_bram_fifo.md
TRAN_BRAM_FIFO -- requirements
Module: tran_bram_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each stored word in bits.
REQ-002 Parameter DEPTH, default 256: number of storage words; power of two, at least 4.
REQ-003 Parameter AF_LEVEL, default DEPTH-4: almost_full asserts when count >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 4: almost_empty asserts when count <= AE_LEVEL.
REQ-005 clk_system  input  1  single system clock; all logic on its rising edge; no other clocks.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 write  input  1  write request.
REQ-008 data_in  input  DATA_WIDTH  write data.
REQ-009 read  input  1  read request.
REQ-010 clear  input  1  synchronous flush.
REQ-011 data_out  output  DATA_WIDTH  registered read data.
REQ-012 data_valid  output  1  data_out holds the word of a read accepted on the previous cycle.
REQ-013 full, empty, almost_full, almost_empty  output  1 each  occupancy flags.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Storage SHALL be one simple-dual-port RAM of DEPTH x DATA_WIDTH, inferable as block RAM, with write and read both on clk_system.
REQ-017 Write and read pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no special handling.
REQ-018 Occupancy SHALL be tracked by count, not by a guard bit; full = (count == DEPTH), empty = (count == 0), both combinational from count.
REQ-019 A read SHALL be accepted iff read && !empty.
REQ-020 A write SHALL be accepted iff write && (!full || a read is accepted in the same cycle).
REQ-021 An accepted write SHALL store data_in at the write pointer and advance it by 1.
REQ-022 An accepted read SHALL advance the read pointer by 1; data_out SHALL update with the addressed word on the same edge, and data_valid SHALL be 1 during the following cycle (1-cycle latency).
REQ-023 count updates: +1 for a write only, -1 for a read only, unchanged for both or for neither.
REQ-024 When empty, with write and read both asserted: the read is rejected, the write is accepted, and underflow is set.
REQ-025 When full, with write and read both asserted: both are accepted and count stays DEPTH.
REQ-026 A rejected write (write && full && no accepted read) SHALL set overflow; RAM contents and pointers remain unchanged.
REQ-027 A rejected read (read && empty) SHALL set underflow; data_out holds its value and data_valid is 0 on the next cycle.
REQ-028 overflow and underflow SHALL stay set until rst or clear.
REQ-029 data_valid SHALL be 0 in any cycle that does not follow an accepted read; data_out holds its last value.
REQ-030 almost_full and almost_empty SHALL be combinational from count using the thresholds in REQ-003 and REQ-004.

Reset
REQ-031 rst SHALL take priority over every other input: pointers, count, data_out, data_valid, overflow and underflow go to 0; empty=1, almost_empty=1, full=0, almost_full=0 on the cycle after the reset edge.
REQ-032 clear SHALL act identically to rst except that RAM contents are not required to change; clear takes priority over write and read in the same cycle.
REQ-033 rst or clear asserted mid-operation SHALL discard any in-flight read: data_valid = 0 on the next cycle.
REQ-034 RAM contents SHALL NOT be reset; after reset the FIFO reads back only data written after reset.

Verification (DATA_WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-035 After rst, write 0x11..0x18 on 8 consecutive cycles -> count steps 1..8; almost_full=1 from count 6; full=1 at count 8; overflow stays 0.
REQ-036 With the FIFO full, write 0x99 alone -> overflow=1, count=8; then 8 reads -> data_out 0x11..0x18, each with data_valid=1 one cycle after its read; empty=1 at the end; 0x99 never appears.
REQ-037 Wrap: write 5 words, read 5, then write 6 more (0xA0..0xA5) -> pointers wrap past 7; reads return 0xA0..0xA5 in order.
REQ-038 Empty FIFO, write=read=1 with data_in=0x3C -> count=1, underflow=1, data_valid=0 on the next cycle; the next read returns 0x3C.
REQ-039 Full FIFO, write=read=1 with data_in=0x5A -> count stays 8, oldest word out with data_valid=1, 0x5A read last after 7 further reads.
REQ-040 With count=3 and a read issued, assert clear on the next cycle -> count=0, empty=1, overflow=0, underflow=0, data_valid=0 on the following cycle.
